// File: rtl/muldiv_seq.sv
// Sequential RV32M/RV64M multiply/divide unit with valid/ready request and result handshakes.
// Multiply retires MUL_STEP multiplier bits per cycle; divide is restoring, one quotient bit per cycle.
module muldiv_seq #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      opcode,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            busy
);

  localparam logic [4:0] OP_MUL    = 5'd0;
  localparam logic [4:0] OP_MULH   = 5'd1;
  localparam logic [4:0] OP_MULHSU = 5'd2;
  localparam logic [4:0] OP_MULHU  = 5'd3;
  localparam logic [4:0] OP_DIV    = 5'd4;
  localparam logic [4:0] OP_DIVU   = 5'd5;
  localparam logic [4:0] OP_REM    = 5'd6;
  localparam logic [4:0] OP_REMU   = 5'd7;

  localparam int            CW       = $clog2(XLEN + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEP - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [4:0]      op_reg;
  logic [XLEN-1:0] opa_reg, opb_reg, rem_reg, rd_reg;
  logic [2*XLEN-1:0] mcand_reg, acc_reg;
  logic            neg_reg, rneg_reg;
  logic [CW-1:0]   cnt_reg;

  // Request decode
  logic            is_mul, is_div, is_rem, sgn1, sgn2, neg1, neg2, div_special, accept;
  logic [XLEN-1:0] mag1, mag2, special_rd;

  always_comb begin
    is_mul = (opcode[4:2] == 3'b000);
    is_div = (opcode[4:2] == 3'b001);
    is_rem = opcode[1];
    sgn1   = (opcode == OP_MUL) || (opcode == OP_MULH) || (opcode == OP_MULHSU) ||
             (opcode == OP_DIV) || (opcode == OP_REM);
    sgn2   = (opcode == OP_MUL) || (opcode == OP_MULH) ||
             (opcode == OP_DIV) || (opcode == OP_REM);
    neg1   = sgn1 & rs1[XLEN-1];
    neg2   = sgn2 & rs2[XLEN-1];
    mag1   = neg1 ? -rs1 : rs1;
    mag2   = neg2 ? -rs2 : rs2;
    div_special = is_div && ((rs2 == '0) ||
                  (((opcode == OP_DIV) || (opcode == OP_REM)) && (rs1 == MOST_NEG) && (rs2 == '1)));
    special_rd = '0;
    if (is_div && (rs2 == '0))
      special_rd = is_rem ? rs1 : '1;
    else if (is_div)
      special_rd = is_rem ? '0 : rs1;
    accept = in_valid & in_ready & ~kill;
  end

  // Multiply step: accumulate the shifted multiplicand times the next multiplier digit
  logic [2*XLEN-1:0] term, acc_next, prod;
  logic [XLEN-1:0]   mul_rd;

  always_comb begin
    term     = mcand_reg * {{(2*XLEN-MUL_STEP){1'b0}}, opb_reg[MUL_STEP-1:0]};
    acc_next = acc_reg + term;
    prod     = neg_reg ? -acc_next : acc_next;
    mul_rd   = (op_reg == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Divide step: opa_reg shifts the dividend out and the quotient in
  logic [XLEN:0]   shifted, diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_next, quo_next, div_rd;

  always_comb begin
    shifted  = {rem_reg, opa_reg[XLEN-1]};
    diff     = shifted - {1'b0, opb_reg};
    q_bit    = ~diff[XLEN];
    rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next = {opa_reg[XLEN-2:0], q_bit};
    div_rd   = op_reg[1] ? (rneg_reg ? -rem_next : rem_next)
                         : (neg_reg  ? -quo_next : quo_next);
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) begin
        if (is_mul)                      state_next = S_MUL;
        else if (is_div && !div_special) state_next = S_DIV;
        else                             state_next = S_DONE;
      end
      S_MUL:  if (kill) state_next = S_IDLE;
              else if (cnt_reg == MUL_LAST) state_next = S_DONE;
      S_DIV:  if (kill) state_next = S_IDLE;
              else if (cnt_reg == DIV_LAST) state_next = S_DONE;
      S_DONE: if (kill || out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == S_IDLE);
    out_valid = (state_reg == S_DONE);
    busy      = (state_reg != S_IDLE);
    rd        = rd_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg    <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      rem_reg   <= '0;
      mcand_reg <= '0;
      acc_reg   <= '0;
      neg_reg   <= 1'b0;
      rneg_reg  <= 1'b0;
      cnt_reg   <= '0;
      rd_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (accept) begin
          op_reg    <= opcode;
          opa_reg   <= mag1;
          opb_reg   <= mag2;
          rem_reg   <= '0;
          mcand_reg <= {{XLEN{1'b0}}, mag1};
          acc_reg   <= '0;
          neg_reg   <= neg1 ^ neg2;
          rneg_reg  <= neg1;
          cnt_reg   <= '0;
          if (!is_mul && !(is_div && !div_special))
            rd_reg <= special_rd;
        end
        S_MUL: if (!kill) begin
          acc_reg   <= acc_next;
          mcand_reg <= mcand_reg << MUL_STEP;
          opb_reg   <= opb_reg >> MUL_STEP;
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == MUL_LAST) rd_reg <= mul_rd;
        end
        S_DIV: if (!kill) begin
          rem_reg <= rem_next;
          opa_reg <= quo_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == DIV_LAST) rd_reg <= div_rd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: results, latencies, special cases, backpressure, kill and reset.
module tb_muldiv_seq;

  localparam logic [4:0] OP_MUL    = 5'd0;
  localparam logic [4:0] OP_MULH   = 5'd1;
  localparam logic [4:0] OP_MULHSU = 5'd2;
  localparam logic [4:0] OP_MULHU  = 5'd3;
  localparam logic [4:0] OP_DIV    = 5'd4;
  localparam logic [4:0] OP_DIVU   = 5'd5;
  localparam logic [4:0] OP_REM    = 5'd6;
  localparam logic [4:0] OP_REMU   = 5'd7;
  localparam logic [4:0] OP_BAD    = 5'd20;

  logic        clk = 1'b0;
  logic        rst, in_valid, kill, out_ready;
  logic [4:0]  opcode;
  logic [31:0] rs1, rs2;
  logic        in_ready, out_valid, busy;
  logic [31:0] rd;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_seq #(.XLEN(32), .MUL_STEP(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs1(rs1), .rs2(rs2), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issues one request, waits (bounded) for the result, then pops it; lat = -1 on timeout.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    opcode = op; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; opcode = OP_BAD; rs1 = $urandom; rs2 = $urandom;
    lat = -1; res = 32'hDEAD_BEEF;
    for (int c = 1; c <= 100; c++) begin
      if (out_valid) begin lat = c; res = rd; break; end
      @(posedge clk); #1;
    end
    if (lat > 0) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    $display("txn op=%0d rs1=%h rs2=%h rd=%h latency=%0d", op, a, b, res, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_rd got=%h want=0", rd); end
  endtask

  task automatic test_mul();
    logic [4:0]  ops [5] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULHU};
    logic [31:0] as  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4};
    logic [31:0] exp [5] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0002};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat);
      n_checks++; if (res !== exp[i]) begin n_fail++; $display("FAIL mul_rd[%0d] got=%h want=%h", i, res, exp[i]); end
      n_checks++; if (lat != 17) begin n_fail++; $display("FAIL mul_latency[%0d] got=%0d want=17", i, lat); end
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat);
      n_checks++; if (res !== exp[i]) begin n_fail++; $display("FAIL div_rd[%0d] got=%h want=%h", i, res, exp[i]); end
      n_checks++; if (lat != 33) begin n_fail++; $display("FAIL div_latency[%0d] got=%0d want=33", i, lat); end
    end
  endtask

  task automatic test_special();
    logic [4:0]  ops [6] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_BAD};
    logic [31:0] as  [6] = '{32'd123, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd9};
    logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd3};
    logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat);
      n_checks++; if (res !== exp[i]) begin n_fail++; $display("FAIL special_rd[%0d] got=%h want=%h", i, res, exp[i]); end
      n_checks++; if (lat != 1) begin n_fail++; $display("FAIL special_latency[%0d] got=%0d want=1", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    @(negedge clk);
    opcode = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (out_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_result_timeout got=%b want=1", seen); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got=%b want=1", c, out_valid); end
      n_checks++; if (rd !== 32'd14) begin n_fail++; $display("FAIL bp_rd[%0d] got=%h want=%h", c, rd, 32'd14); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b want=0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("txn op=%0d rs1=%h rs2=%h rd=%h held=10", OP_DIVU, 32'd100, 32'd7, rd);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_pop_out_valid got=%b want=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_kill_rst();
    bit seen;
    logic [31:0] res;
    int lat;
    // kill on cycle 5 of a divide
    @(negedge clk);
    opcode = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got=%b want=0", busy); end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL kill_no_result got=%b want=0", seen); end
    $display("txn op=%0d rs1=%h rs2=%h killed", OP_DIV, 32'd1000, 32'd3);
    // request presented together with kill while idle is dropped
    @(negedge clk);
    opcode = OP_MUL; rs1 = 32'd2; rs2 = 32'd3; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_kill_accept got=%b want=0", busy); end
    // reset on cycle 3 of a multiply
    @(negedge clk);
    opcode = OP_MUL; rs1 = 32'd11; rs2 = 32'd13; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_rd got=%h want=0", rd); end
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_result got=%b want=0", seen); end
    $display("txn op=%0d rs1=%h rs2=%h reset", OP_MUL, 32'd11, 32'd13);
    run_op(OP_MUL, 32'd6, 32'd7, res, lat);
    n_checks++; if (res !== 32'd42) begin n_fail++; $display("FAIL after_rst_mul_rd got=%h want=%h", res, 32'd42); end
    n_checks++; if (lat != 17) begin n_fail++; $display("FAIL after_rst_mul_latency got=%0d want=17", lat); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    opcode = OP_BAD; rs1 = '0; rs2 = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_kill_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide unit for the RV32M/RV64M execute stage, replacing the single-cycle combinational multiplier.
- Supports MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Operands and results are exchanged over a valid/ready handshake.
- Multiply retires MUL_STEP bits per cycle; divide is restoring, 1 bit per cycle.

Parameters:
XLEN, 32, operand/result width (32 or 64)
MUL_STEP, 2, multiplier bits consumed per cycle; must divide XLEN (1, 2, 4, 8)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
opcode  in  5  ALU_MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU encodings from defines.vh
rs1  in  XLEN  operand 1 (dividend / multiplicand)
rs2  in  XLEN  operand 2 (divisor / multiplier)
kill  in  1  abort in-flight operation (pipeline flush)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
rd  out  XLEN  result
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high, clk rising edge): state=IDLE, out_valid=0, rd=0, busy=0, in_ready=1. Reset mid-operation discards all work; no result is produced.
- States: IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE). Request accepted on in_valid & in_ready; opcode/rs1/rs2 are latched that edge and may change afterwards.
- IDLE -> MUL on an accepted multiply opcode.
- IDLE -> DIV on an accepted divide opcode, unless it is a special case.
- IDLE -> DONE directly for divide special cases and unknown opcodes. rd is computed on the accept edge; total latency 1 cycle to out_valid.
- Multiply setup:
  - Magnitudes |rs1| and |rs2| are taken per signedness: MUL/MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU both unsigned.
  - neg = sign(rs1) XOR sign(rs2), over signed operands only.
  - 2*XLEN accumulator cleared.
- MUL state: each cycle adds |rs1| x (next MUL_STEP bits of |rs2|, LSB first), shifted appropriately; counter runs XLEN/MUL_STEP cycles.
- MUL finish: product negated if neg. rd = low XLEN bits for MUL, high XLEN bits for MULH/MULHSU/MULHU. Then -> DONE.
- Multiply latency: XLEN/MUL_STEP + 1 cycles accept-to-out_valid (17 at defaults).
- Divide setup: DIV/REM use magnitudes; DIVU/REMU use raw values.
  - qneg = sign(rs1) XOR sign(rs2).
  - rneg = sign(rs1).
- DIV state: restoring division, one quotient bit per cycle, XLEN cycles. Quotient negated if qneg; remainder negated if rneg. Then -> DONE.
- Divide latency: XLEN + 1 cycles (33 at XLEN=32).
- Divide special cases (1-cycle, to DONE):
  - rs2==0: DIV/DIVU rd = all ones; REM/REMU rd = rs1.
  - DIV with rs1 = most-negative and rs2 = -1: rd = rs1.
  - REM with rs1 = most-negative and rs2 = -1: rd = 0.
- Unknown opcode: rd=0, 1-cycle.
- DONE: out_valid=1; rd stable until out_ready. On out_valid & out_ready -> IDLE, out_valid=0. A new request is not accepted in the same cycle (in_ready low in DONE).
- kill: in MUL, DIV or DONE -> IDLE next edge, out_valid=0, no result. kill in IDLE is ignored, and a request presented with kill is not accepted. rst has priority over kill.
- rd holds its last value outside DONE. Arithmetic is modulo 2^XLEN; no exceptions raised.

Test Plan:
- MUL rs1=-3 (0xFFFFFFFD), rs2=7 -> out_valid exactly 17 cycles after accept, rd=0xFFFFFFEB.
- MULH/MULHSU/MULHU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF:
  - MULH -> rd=0x00000000.
  - MULHSU -> rd=0xFFFFFFFF.
  - MULHU -> rd=0xFFFFFFFE.
- DIV rs1=-7, rs2=2 -> rd=-3 (0xFFFFFFFD), 33 cycles. REM same operands -> rd=-1 (0xFFFFFFFF). DIVU 100/7 -> rd=14. REMU 100/7 -> rd=2.
- Special cases, each with out_valid 1 cycle after accept:
  - DIVU x/0 -> rd=0xFFFFFFFF.
  - REM 5/0 -> rd=5.
  - DIV 0x80000000 / -1 -> rd=0x80000000.
  - REM same operands -> rd=0.
- Backpressure: out_ready low for 10 cycles after out_valid -> rd and out_valid stable, in_ready=0. out_ready pulse -> IDLE, in_ready=1 next cycle.
- kill at cycle 5 of DIV, then rst asserted at cycle 3 of a later MUL -> no out_valid pulse either time, busy=0 next cycle, and a following MUL 6x7 returns rd=42.
